// File: rtl/mem_rw_device_if.sv
// Read/write request bus between the cache memory-side controller and
// the backing memory device; one address/valid/ready channel per direction.
//   master : controller side (drives requests, consumes responses)
//   slave  : device side
//   device : device side, alias of slave used by mem_rw_device
interface axi_bus_rw #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_addr_valid;
    logic                  read_addr_ready;
    logic [WIDTH-1:0]      read_data;
    logic                  read_data_valid;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  write_addr_valid;
    logic                  write_addr_ready;
    logic [WIDTH-1:0]      write_data;
    logic                  write_resp_valid;
    logic [WIDTH/8-1:0]    strobe;
    logic [1:0]            size;
    logic                  lu;

    modport master (
        output read_addr, read_addr_valid, write_addr, write_addr_valid,
        output write_data, strobe, size, lu,
        input  read_addr_ready, read_data, read_data_valid,
        input  write_addr_ready, write_resp_valid
    );

    modport slave (
        input  read_addr, read_addr_valid, write_addr, write_addr_valid,
        input  write_data, strobe, size, lu,
        output read_addr_ready, read_data, read_data_valid,
        output write_addr_ready, write_resp_valid
    );

    modport device (
        input  read_addr, read_addr_valid, write_addr, write_addr_valid,
        input  write_data, strobe, size, lu,
        output read_addr_ready, read_data, read_data_valid,
        output write_addr_ready, write_resp_valid
    );
endinterface

// File: rtl/mem_rw_device.sv
// Backing memory device: one read or write at a time, fixed LATENCY
// cycles from accept to a single-cycle response pulse.
// Ports: clk, rst_n (async active-low), bus (axi_bus_rw.device),
//        err_misaligned (only with MEM_DEVICE_MISALIGN_TRAP_EN defined).
// Writes honour byte strobes; reads are lane-extracted by size and
// sign/zero-extended by lu. Memory contents are not reset.
module mem_rw_device #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
    axi_bus_rw.device   bus,
    output logic        err_misaligned
`else
    axi_bus_rw.device   bus
`endif
);
    localparam int WORD_SIZE = WIDTH / 8;
    localparam int OFF_W     = $clog2(WORD_SIZE);
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int AW        = OFF_W + IDX_W;
    localparam int CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic                   lu_q, lu_d;
    logic [WORD_SIZE-1:0]   strb_q, strb_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   wresp_q, wresp_d;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
    logic                   err_q, err_d;
`endif

    logic [WIDTH-1:0]       mem [DEPTH_WORDS];
    logic [IDX_W-1:0]       idx;
    logic [OFF_W-1:0]       boff;
    logic [WIDTH-1:0]       word_rd;
    logic [WIDTH-1:0]       word_wr;
    logic [WIDTH-1:0]       rd_ext;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic                   misal;
    logic                   mem_we;

    assign idx  = addr_q[OFF_W +: IDX_W];
    assign boff = addr_q[OFF_W-1:0];

    // Lane extraction, byte-lane merge and misalignment decode
    always_comb begin
        word_rd = mem[idx];
        byte_v  = word_rd[{boff, 3'b000} +: 8];
        half_v  = word_rd[{boff[OFF_W-1:1], 4'b0000} +: 16];
        rd_ext  = word_rd;
        unique case (size_q)
            2'd0: rd_ext = lu_q ? {{(WIDTH-8){1'b0}}, byte_v}
                                : {{(WIDTH-8){byte_v[7]}}, byte_v};
            2'd1: rd_ext = lu_q ? {{(WIDTH-16){1'b0}}, half_v}
                                : {{(WIDTH-16){half_v[15]}}, half_v};
            default: rd_ext = word_rd;
        endcase
        word_wr = word_rd;
        for (int i = 0; i < WORD_SIZE; i++) begin
            if (strb_q[i]) word_wr[8*i +: 8] = wdata_q[8*i +: 8];
        end
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
        misal = ((size_q == 2'd1) && boff[0])
             || (size_q[1] && (boff != '0));
`else
        misal = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        lu_d     = lu_q;
        strb_d   = strb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wresp_d  = 1'b0;
        mem_we   = 1'b0;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Write wins when both requests arrive together
                if (bus.write_addr_valid) begin
                    state_d = WR_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    addr_d  = bus.write_addr[AW-1:0];
                    size_d  = bus.size;
                    lu_d    = bus.lu;
                    strb_d  = bus.strobe;
                    wdata_d = bus.write_data;
                end else if (bus.read_addr_valid) begin
                    state_d = RD_WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    addr_d  = bus.read_addr[AW-1:0];
                    size_d  = bus.size;
                    lu_d    = bus.lu;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
                    err_d   = misal;
`endif
                    if (state_q == RD_WAIT) begin
                        rvalid_d = 1'b1;
                        rdata_d  = misal ? '1 : rd_ext;
                    end else begin
                        wresp_d = 1'b1;
                        mem_we  = !misal;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            lu_q     <= 1'b0;
            strb_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wresp_q  <= 1'b0;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            lu_q     <= lu_d;
            strb_q   <= strb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wresp_q  <= wresp_d;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    // Array is not reset; mem_we is only reachable out of WR_WAIT
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= word_wr;
    end

    assign bus.read_addr_ready  = (state_q == IDLE);
    assign bus.write_addr_ready = (state_q == IDLE);
    assign bus.read_data        = rdata_q;
    assign bus.read_data_valid  = rvalid_q;
    assign bus.write_resp_valid = wresp_q;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
    assign err_misaligned       = err_q;
`endif
endmodule

// File: tb/tb_mem_rw_device.sv
// Directed bench for mem_rw_device: latency, strobes, extension,
// write priority, mid-transaction reset and optional misalign trap.
module tb_mem_rw_device;
    localparam int LAT = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
    logic err;
`endif

    axi_bus_rw #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_rw_device #(
        .WIDTH(32),
        .DEPTH_WORDS(1024),
        .LATENCY(LAT),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
        .bus(bus),
        .err_misaligned(err)
`else
        .bus(bus)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, LAT wait cycles, RESP, back to IDLE
    task automatic run(input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] sz, input bit l,
                       input logic [31:0] exp, input bit e);
        @(negedge clk);
        if (wr) begin
            bus.write_addr       = a;
            bus.write_data       = d;
            bus.strobe           = s;
            bus.write_addr_valid = 1'b1;
        end else begin
            bus.read_addr        = a;
            bus.read_addr_valid  = 1'b1;
        end
        bus.size = sz;
        bus.lu   = l;
        @(posedge clk);
        #1;
        bus.write_addr_valid = 1'b0;
        bus.read_addr_valid  = 1'b0;
        chk("busy_after_accept", {31'b0, bus.read_addr_ready}, 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            chk("wresp_timing", {31'b0, bus.write_resp_valid},
                {31'b0, (wr && k == LAT)});
            chk("rvalid_timing", {31'b0, bus.read_data_valid},
                {31'b0, (!wr && k == LAT)});
            chk("ready_low", {31'b0, bus.write_addr_ready}, 32'd0);
            if (k == LAT && !wr) chk("read_data", bus.read_data, exp);
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
            if (k == LAT) chk("err_misaligned", {31'b0, err}, {31'b0, e});
`endif
        end
        @(posedge clk);
        #1;
        chk("ready_back", {31'b0, bus.read_addr_ready}, 32'd1);
        chk("pulse_single", {30'b0, bus.read_data_valid,
            bus.write_resp_valid}, 32'd0);
    endtask

    initial begin
        vectors              = 0;
        miscompares          = 0;
        rst_n                = 1'b0;
        bus.read_addr        = '0;
        bus.read_addr_valid  = 1'b0;
        bus.write_addr       = '0;
        bus.write_addr_valid = 1'b0;
        bus.write_data       = '0;
        bus.strobe           = '0;
        bus.size             = '0;
        bus.lu               = 1'b0;
        #12;
        chk("rst_rd_ready", {31'b0, bus.read_addr_ready}, 32'd1);
        chk("rst_wr_ready", {31'b0, bus.write_addr_ready}, 32'd1);
        chk("rst_rdata", bus.read_data, 32'd0);
        chk("rst_rvalid", {31'b0, bus.read_data_valid}, 32'd0);
        chk("rst_wresp", {31'b0, bus.write_resp_valid}, 32'd0);
`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
        chk("rst_err", {31'b0, err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Word write then read back
        run(1, 32'h10, 32'hCAFEBABE, 4'hF, 2'd2, 0, 32'h0, 0);
        run(0, 32'h10, 32'h0, 4'h0, 2'd2, 0, 32'hCAFEBABE, 0);
        // Single-lane strobe: byte1 <= 0x11
        run(1, 32'h10, 32'h00001100, 4'h2, 2'd2, 0, 32'h0, 0);
        run(0, 32'h10, 32'h0, 4'h0, 2'd2, 0, 32'hCAFE11BE, 0);
        // Extraction and extension
        run(0, 32'h13, 32'h0, 4'h0, 2'd0, 0, 32'hFFFFFFCA, 0);
        run(0, 32'h13, 32'h0, 4'h0, 2'd0, 1, 32'h000000CA, 0);
        run(0, 32'h12, 32'h0, 4'h0, 2'd1, 0, 32'hFFFFCAFE, 0);
        run(0, 32'h12, 32'h0, 4'h0, 2'd1, 1, 32'h0000CAFE, 0);
        run(0, 32'h10, 32'h0, 4'h0, 2'd1, 0, 32'h000011BE, 0);
        run(0, 32'h10, 32'h0, 4'h0, 2'd0, 0, 32'hFFFFFFBE, 0);
        run(0, 32'h10, 32'h0, 4'h0, 2'd3, 1, 32'hCAFE11BE, 0);
        // Zero strobe: response but no change; upper address wraps
        run(1, 32'h10, 32'h12345678, 4'h0, 2'd2, 0, 32'h0, 0);
        run(0, 32'h1010, 32'h0, 4'h0, 2'd2, 0, 32'hCAFE11BE, 0);

        // Simultaneous read and write: write first, read sees new data
        @(negedge clk);
        bus.write_addr       = 32'h30;
        bus.write_data       = 32'hA5A55A5A;
        bus.strobe           = 4'hF;
        bus.write_addr_valid = 1'b1;
        bus.read_addr        = 32'h30;
        bus.read_addr_valid  = 1'b1;
        bus.size             = 2'd2;
        bus.lu               = 1'b0;
        @(posedge clk);
        #1;
        bus.write_addr_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            chk("both_wresp", {31'b0, bus.write_resp_valid},
                {31'b0, (k == LAT)});
            chk("both_no_rvalid", {31'b0, bus.read_data_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("both_idle_gap", {31'b0, bus.read_addr_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.read_addr_valid = 1'b0;
        chk("both_rd_accept", {31'b0, bus.read_addr_ready}, 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            chk("both_rvalid", {31'b0, bus.read_data_valid},
                {31'b0, (k == LAT)});
            if (k == LAT) chk("both_rdata", bus.read_data, 32'hA5A55A5A);
        end
        @(posedge clk);
        #1;

        // Reset two cycles after a write accept drops the write
        run(1, 32'h20, 32'h11223344, 4'hF, 2'd2, 0, 32'h0, 0);
        @(negedge clk);
        bus.write_addr       = 32'h20;
        bus.write_data       = 32'hDEADBEEF;
        bus.strobe           = 4'hF;
        bus.write_addr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.write_addr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'b0, bus.write_addr_ready}, 32'd1);
        chk("rst_mid_wresp", {31'b0, bus.write_resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("rst_no_resp", {31'b0, bus.write_resp_valid}, 32'd0);
            chk("rst_ready", {31'b0, bus.read_addr_ready}, 32'd1);
        end
        run(0, 32'h20, 32'h0, 4'h0, 2'd2, 0, 32'h11223344, 0);

`ifdef MEM_DEVICE_MISALIGN_TRAP_EN
        run(1, 32'h11, 32'h12345678, 4'hF, 2'd2, 0, 32'h0, 1);
        run(0, 32'h10, 32'h0, 4'h0, 2'd2, 0, 32'hCAFE11BE, 0);
        run(0, 32'h11, 32'h0, 4'h0, 2'd2, 0, 32'hFFFFFFFF, 1);
        run(0, 32'h13, 32'h0, 4'h0, 2'd1, 1, 32'hFFFFFFFF, 1);
        run(0, 32'h12, 32'h0, 4'h0, 2'd1, 1, 32'h0000CAFE, 0);
`else
        // Misaligned low bits ignored: half uses addr[1], word none
        run(0, 32'h11, 32'h0, 4'h0, 2'd1, 1, 32'h000011BE, 0);
        run(0, 32'h13, 32'h0, 4'h0, 2'd2, 0, 32'hCAFE11BE, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
